// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter and its per-unit FIFOs.
// Unit indices also define the round-robin scan order X -> Y -> M -> X.
package wb_arbiter_pkg;

    localparam int UNIT_X     = 0;
    localparam int UNIT_Y     = 1;
    localparam int UNIT_M     = 2;
    localparam int NUM_UNITS  = 3;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] regdest;
        logic [DATA_W-1:0]     wbvalue;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

    // One-hot register mask; r0 never produces a pending bit.
    function automatic logic [NUM_REGS-1:0] reg_decode(input logic [REG_ADDR_W-1:0] r);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (r != '0) m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous per-unit result FIFO; a push into a full FIFO is accepted only
// when a pop happens on the same edge. Also reports the mask of queued regdests.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic [ENTRY_W-1:0]  din,
    output logic [ENTRY_W-1:0]  dout,
    output logic [CNT_W-1:0]    count,
    output logic                full,
    output logic                empty,
    output logic [NUM_REGS-1:0] dest_mask
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    wb_entry_t        mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wb_entry_t'(din);
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        logic [PTR_W-1:0] off;
        off       = '0;
        dest_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr;
            if (CNT_W'(off) < count) dest_mask = dest_mask | reg_decode(mem[i].regdest);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Merges X/Y/M results into the single register-file write port through
// per-unit FIFOs and a rotating-priority grant; reports stall and pending regs.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SLACK = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  x_wb_regdest,
    input  logic        x_wb_writereg,
    input  logic [31:0] x_wb_wbvalue,
    input  logic [4:0]  y_wb_regdest,
    input  logic        y_wb_writereg,
    input  logic [31:0] y_wb_wbvalue,
    input  logic [4:0]  m_wb_regdest,
    input  logic        m_wb_writereg,
    input  logic [31:0] m_wb_wbvalue,
    output logic [4:0]  ex_wb_regdest,
    output logic        ex_wb_writereg,
    output logic [31:0] ex_wb_wbvalue,
    output logic        wb_stall,
    output logic [31:0] wb_pend_mask,
    output logic        wb_overflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [NUM_UNITS-1:0] push_req;
    logic [NUM_UNITS-1:0] pop;
    logic [NUM_UNITS-1:0] full;
    logic [NUM_UNITS-1:0] empty;
    logic [ENTRY_W-1:0]   din   [NUM_UNITS];
    logic [ENTRY_W-1:0]   dout  [NUM_UNITS];
    logic [CNT_W-1:0]     count [NUM_UNITS];
    logic [NUM_REGS-1:0]  fifo_mask [NUM_UNITS];

    logic       [1:0] rr_ptr;
    logic       [1:0] rr_next;
    logic       [1:0] grant_unit;
    logic             grant_valid;
    wb_entry_t        grant_entry;

    // Writes to r0 are discarded before they ever occupy a FIFO slot.
    assign push_req[UNIT_X] = x_wb_writereg && (x_wb_regdest != '0);
    assign push_req[UNIT_Y] = y_wb_writereg && (y_wb_regdest != '0);
    assign push_req[UNIT_M] = m_wb_writereg && (m_wb_regdest != '0);
    assign din[UNIT_X]      = {x_wb_regdest, x_wb_wbvalue};
    assign din[UNIT_Y]      = {y_wb_regdest, y_wb_wbvalue};
    assign din[UNIT_M]      = {m_wb_regdest, m_wb_wbvalue};

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_fifo
        wb_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (push_req[u]),
            .pop       (pop[u]),
            .din       (din[u]),
            .dout      (dout[u]),
            .count     (count[u]),
            .full      (full[u]),
            .empty     (empty[u]),
            .dest_mask (fifo_mask[u])
        );
    end

    always_comb begin
        int u;
        u           = 0;
        grant_valid = 1'b0;
        grant_unit  = rr_ptr;
        grant_entry = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            u = int'(rr_ptr) + i;
            if (u >= NUM_UNITS) u -= NUM_UNITS;
            if (!grant_valid && !empty[u]) begin
                grant_valid = 1'b1;
                grant_unit  = 2'(u);
                grant_entry = wb_entry_t'(dout[u]);
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_UNITS; i++) pop[i] = grant_valid && (grant_unit == 2'(i));
        rr_next = (grant_unit == 2'(UNIT_M)) ? 2'(UNIT_X) : grant_unit + 2'd1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr         <= 2'(UNIT_X);
            ex_wb_writereg <= 1'b0;
            ex_wb_regdest  <= '0;
            ex_wb_wbvalue  <= '0;
            wb_overflow    <= 1'b0;
        end else begin
            if (grant_valid) begin
                rr_ptr         <= rr_next;
                ex_wb_writereg <= 1'b1;
                ex_wb_regdest  <= grant_entry.regdest;
                ex_wb_wbvalue  <= grant_entry.wbvalue;
            end else begin
                ex_wb_writereg <= 1'b0;
            end
            if (|(push_req & full & ~pop)) wb_overflow <= 1'b1;
        end
    end

    always_comb begin
        wb_stall = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++)
            if (count[i] >= CNT_W'(DEPTH - SLACK)) wb_stall = 1'b1;
    end

    always_comb begin
        wb_pend_mask = fifo_mask[UNIT_X] | fifo_mask[UNIT_Y] | fifo_mask[UNIT_M];
        if (ex_wb_writereg) wb_pend_mask = wb_pend_mask | reg_decode(ex_wb_regdest);
    end

endmodule
